// File: rtl/conv_engine_pkg.sv
// Shared types and helpers for the line convolution accumulate engine:
// FSM encoding, control-bit positions and the saturate/wrap fitting function.
package conv_engine_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WLOAD = 2'd1,
    ST_RUN   = 2'd2,
    ST_OUT   = 2'd3
  } state_e;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_SAT_BIT = 1;

  // Wide working width for accumulation before fitting into the accumulator.
  localparam int WIDE_W = 64;

  typedef struct packed {
    logic signed [WIDE_W-1:0] value;
    logic                     ovf;
  } fit_t;

  // Fit a wide signed value into acc_w bits: clamp when sat=1, else two's
  // complement truncation. ovf flags any change of value.
  function automatic fit_t fit_acc(input logic signed [WIDE_W-1:0] v,
                                   input int acc_w, input logic sat);
    logic signed [WIDE_W-1:0] max_v;
    logic signed [WIDE_W-1:0] min_v;
    logic signed [WIDE_W-1:0] wrapped;
    fit_t r;
    max_v   = (WIDE_W'(1) <<< (acc_w - 1)) - WIDE_W'(1);
    min_v   = -max_v - WIDE_W'(1);
    wrapped = (v <<< (WIDE_W - acc_w)) >>> (WIDE_W - acc_w);
    if (sat) begin
      if (v > max_v) begin
        r.value = max_v;
        r.ovf   = 1'b1;
      end else if (v < min_v) begin
        r.value = min_v;
        r.ovf   = 1'b1;
      end else begin
        r.value = v;
        r.ovf   = 1'b0;
      end
    end else begin
      r.value = wrapped;
      r.ovf   = (wrapped != v);
    end
    return r;
  endfunction

endpackage

// File: rtl/line_conv2d_accum_engine_kcpe_dot.sv
// One kernel's combinational dot product of an activation beat against its
// weight set; the output is wide enough that no sum can overflow.
module kcpe_dot #(
  parameter int BIT_WIDTH = 8,
  parameter int NUM_TERMS = 9,
  parameter int OUT_WIDTH = 2 * BIT_WIDTH + $clog2(NUM_TERMS)
) (
  input  logic        [BIT_WIDTH*NUM_TERMS-1:0] data_i,
  input  logic        [BIT_WIDTH*NUM_TERMS-1:0] weight_i,
  output logic signed [OUT_WIDTH-1:0]           sum_o
);

  logic signed [2*BIT_WIDTH-1:0] prod [NUM_TERMS];

  for (genvar i = 0; i < NUM_TERMS; i++) begin : g_term
    logic signed [BIT_WIDTH-1:0] a;
    logic signed [BIT_WIDTH-1:0] b;
    assign a       = data_i[i*BIT_WIDTH +: BIT_WIDTH];
    assign b       = weight_i[i*BIT_WIDTH +: BIT_WIDTH];
    assign prod[i] = a * b;
  end

  always_comb begin
    sum_o = '0;
    for (int i = 0; i < NUM_TERMS; i++) begin
      sum_o = sum_o + OUT_WIDTH'(prod[i]);
    end
  end

endmodule

// File: rtl/line_conv2d_accum_engine.sv
// Multi-kernel line convolution engine: loads a weight set, accumulates
// accum_len beats per result and emits weightinterval results per set.
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high; a producer holds data stable while valid is high and not accepted.
module line_conv2d_accum_engine
  import conv_engine_pkg::*;
#(
  parameter int BIT_WIDTH   = 8,
  parameter int NUM_CHANNEL = 3,
  parameter int NUM_KERNEL  = 4,
  parameter int NUM_POS     = 3,
  parameter int ACC_WIDTH   = 20,
  parameter int REG_WIDTH   = 32
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_POS-1:0]        i_data,
  input  logic                                            i_data_val,
  output logic                                            o_data_rdy,
  input  logic [BIT_WIDTH*NUM_CHANNEL*NUM_POS*NUM_KERNEL-1:0] i_weight,
  input  logic                                            i_weight_val,
  output logic                                            o_weight_rdy,
  output logic [ACC_WIDTH*NUM_KERNEL-1:0]                 o_psum,
  output logic                                            o_psum_val,
  input  logic                                            i_psum_rdy,
  input  logic [REG_WIDTH-1:0]                            i_conf_ctrl,
  input  logic [REG_WIDTH-1:0]                            i_conf_accum_len,
  input  logic [REG_WIDTH-1:0]                            i_conf_weightinterval,
  output logic                                            o_busy,
  output logic                                            o_ovf,
  output logic [1:0]                                      o_dbg_state
);

  localparam int NUM_TERMS = NUM_POS * NUM_CHANNEL;
  localparam int KW        = BIT_WIDTH * NUM_TERMS;
  localparam int DOT_W     = 2 * BIT_WIDTH + $clog2(NUM_TERMS);

  state_e                        state_q;
  logic [KW*NUM_KERNEL-1:0]      w_q;
  logic signed [ACC_WIDTH-1:0]   acc_q [NUM_KERNEL];
  logic signed [ACC_WIDTH-1:0]   acc_d [NUM_KERNEL];
  logic [ACC_WIDTH*NUM_KERNEL-1:0] psum_q;
  logic [REG_WIDTH-1:0]          len_q, int_q, beat_cnt_q, res_cnt_q;
  logic signed [DOT_W-1:0]       beat_sum [NUM_KERNEL];
  logic                          en, sat, first_beat, last_beat, ovf_any;
  logic                          unused_bits;

  assign en          = i_conf_ctrl[CTRL_EN_BIT];
  assign sat         = i_conf_ctrl[CTRL_SAT_BIT];
  assign first_beat  = (beat_cnt_q == '0);
  assign last_beat   = ((beat_cnt_q + REG_WIDTH'(1)) == len_q);
  assign o_psum      = psum_q;
  assign o_dbg_state = state_q;

  for (genvar k = 0; k < NUM_KERNEL; k++) begin : g_kernel
    kcpe_dot #(
      .BIT_WIDTH (BIT_WIDTH),
      .NUM_TERMS (NUM_TERMS),
      .OUT_WIDTH (DOT_W)
    ) u_dot (
      .data_i   (i_data),
      .weight_i (w_q[k*KW +: KW]),
      .sum_o    (beat_sum[k])
    );
  end

  // Next accumulator values for an accepted beat, fitted to ACC_WIDTH.
  always_comb begin
    logic signed [WIDE_W-1:0] wide;
    fit_t                     fit;
    ovf_any     = 1'b0;
    unused_bits = ^i_conf_ctrl[REG_WIDTH-1:2];
    for (int k = 0; k < NUM_KERNEL; k++) begin
      wide = first_beat ? WIDE_W'(beat_sum[k])
                        : WIDE_W'(acc_q[k]) + WIDE_W'(beat_sum[k]);
      fit  = fit_acc(wide, ACC_WIDTH, sat);
      acc_d[k]    = fit.value[ACC_WIDTH-1:0];
      ovf_any     = ovf_any | fit.ovf;
      unused_bits = unused_bits ^ (^fit.value[WIDE_W-1:ACC_WIDTH]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      w_q          <= '0;
      psum_q       <= '0;
      len_q        <= '0;
      int_q        <= '0;
      beat_cnt_q   <= '0;
      res_cnt_q    <= '0;
      o_data_rdy   <= 1'b0;
      o_weight_rdy <= 1'b0;
      o_psum_val   <= 1'b0;
      o_busy       <= 1'b0;
      o_ovf        <= 1'b0;
      for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en) begin
            state_q      <= ST_WLOAD;
            o_weight_rdy <= 1'b1;
            o_busy       <= 1'b1;
            len_q        <= (i_conf_accum_len == '0) ? REG_WIDTH'(1) : i_conf_accum_len;
            int_q        <= (i_conf_weightinterval == '0) ? REG_WIDTH'(1) : i_conf_weightinterval;
            beat_cnt_q   <= '0;
            res_cnt_q    <= '0;
          end
        end
        ST_WLOAD: begin
          if (!en) begin
            state_q      <= ST_IDLE;
            o_weight_rdy <= 1'b0;
            o_busy       <= 1'b0;
            res_cnt_q    <= '0;
          end else if (i_weight_val) begin
            w_q          <= i_weight;
            state_q      <= ST_RUN;
            o_weight_rdy <= 1'b0;
            o_data_rdy   <= 1'b1;
          end
        end
        ST_RUN: begin
          if (!en) begin
            state_q    <= ST_IDLE;
            o_data_rdy <= 1'b0;
            o_busy     <= 1'b0;
            beat_cnt_q <= '0;
            res_cnt_q  <= '0;
            for (int k = 0; k < NUM_KERNEL; k++) acc_q[k] <= '0;
          end else if (i_data_val) begin
            acc_q <= acc_d;
            if (ovf_any) o_ovf <= 1'b1;
            if (last_beat) begin
              beat_cnt_q <= '0;
              state_q    <= ST_OUT;
              o_data_rdy <= 1'b0;
              o_psum_val <= 1'b1;
              for (int k = 0; k < NUM_KERNEL; k++) psum_q[k*ACC_WIDTH +: ACC_WIDTH] <= acc_d[k];
            end else begin
              beat_cnt_q <= beat_cnt_q + REG_WIDTH'(1);
            end
          end
        end
        ST_OUT: begin
          // A pending result always completes its handshake, even if disabled.
          if (i_psum_rdy) begin
            o_psum_val <= 1'b0;
            if (!en) begin
              state_q   <= ST_IDLE;
              o_busy    <= 1'b0;
              res_cnt_q <= '0;
            end else if ((res_cnt_q + REG_WIDTH'(1)) >= int_q) begin
              res_cnt_q    <= '0;
              state_q      <= ST_WLOAD;
              o_weight_rdy <= 1'b1;
            end else begin
              res_cnt_q  <= res_cnt_q + REG_WIDTH'(1);
              state_q    <= ST_RUN;
              o_data_rdy <= 1'b1;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/line_conv2d_accum_engine.md
LINE_CONV2D_ACCUM_ENGINE -- requirements
Module: line_conv2d_accum_engine

Interface
REQ-001 Parameters SHALL be: BIT_WIDTH, 8, signed operand width; NUM_CHANNEL, 3, channels per position; NUM_KERNEL, 4, kernels computed in parallel; NUM_POS, 3, positions per beat; ACC_WIDTH, 20, signed accumulator width; REG_WIDTH, 32, config register width.
REQ-002 clk  in  1  clock; all logic on rising edge.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 i_data  in  BIT_WIDTH*NUM_CHANNEL*NUM_POS  activation beat, position-major, channel 0 in LSBs of each position.
REQ-005 i_data_val  in  1  / o_data_rdy  out  1  data handshake; a beat transfers when both are high.
REQ-006 i_weight  in  BIT_WIDTH*NUM_CHANNEL*NUM_POS*NUM_KERNEL  weight set, kernel-major, then position, then channel.
REQ-007 i_weight_val  in  1  / o_weight_rdy  out  1  weight handshake.
REQ-008 o_psum  out  ACC_WIDTH*NUM_KERNEL  result, kernel 0 in LSBs.
REQ-009 o_psum_val  out  1  / i_psum_rdy  in  1  result handshake.
REQ-010 i_conf_ctrl  in  REG_WIDTH  bit0 enable, bit1 saturate (1) / wrap (0); other bits ignored.
REQ-011 i_conf_accum_len  in  REG_WIDTH  beats summed per result; 0 treated as 1.
REQ-012 i_conf_weightinterval  in  REG_WIDTH  results produced per weight set; 0 treated as 1.
REQ-013 o_busy  out  1  high when FSM is not IDLE.
REQ-014 o_ovf  out  1  sticky overflow flag.

Function
REQ-015 FSM states SHALL be IDLE, WLOAD, RUN, OUT.
REQ-016 IDLE -> WLOAD when enable=1; accum_len and weightinterval SHALL be latched on this transition and held until the next IDLE exit.
REQ-017 o_weight_rdy SHALL be high only in WLOAD; on weight transfer the set is registered and the FSM enters RUN next cycle.
REQ-018 o_data_rdy SHALL be high only in RUN; at most one beat accepted per cycle.
REQ-019 Per accepted beat, for each kernel k: beat_sum[k] = signed sum over all positions and channels of data*weight[k], computed at full width without loss.
REQ-020 acc[k] SHALL load beat_sum[k] on the first beat of a result and acc[k]+beat_sum[k] on later beats.
REQ-021 Saturate mode: out-of-range accumulations clamp to +/-(2^(ACC_WIDTH-1)) limits; wrap mode: truncate to ACC_WIDTH two's complement.
REQ-022 Any clamp or truncation that changes value SHALL set o_ovf, in either mode.
REQ-023 After the accum_len-th beat, the FSM SHALL enter OUT the next cycle with o_psum_val=1 and o_psum=acc.
REQ-024 In OUT, o_psum and o_psum_val SHALL remain stable until i_psum_rdy=1; same-cycle valid and ready completes the transfer.
REQ-025 After a result transfer, result count increments; on reaching weightinterval it resets to 0 and the FSM enters WLOAD, else RUN.
REQ-026 Enable low in WLOAD or RUN: next state IDLE; partial accumulation and counters discarded.
REQ-027 Enable low in OUT: the pending result SHALL still complete its handshake, then IDLE.
REQ-028 Minimum throughput SHALL be one result per accum_len+1 cycles with continuous valid/ready.

Reset
REQ-029 rst SHALL force IDLE and zero acc, counters, o_psum, o_psum_val, o_data_rdy, o_weight_rdy, o_busy and o_ovf, including mid-operation.
REQ-030 Weight registers SHALL also reset to 0; the first result after reset SHALL use only weights loaded after reset.

Structure
REQ-031 FSM state encoding, ctrl-bit indices and the saturate/wrap function SHALL live in shared package conv_engine_pkg.
REQ-032 One sub-module kcpe_dot (one kernel's NUM_POS*NUM_CHANNEL dot product, combinational) SHALL be instantiated NUM_KERNEL times.

Verification (default parameters)
REQ-033 Weights all 1, data all 1, accum_len=1, interval=1 -> each kernel psum 9, o_psum_val 1 cycle after data beat, o_weight_rdy next.
REQ-034 Weights 3, data 2, accum_len=4 -> each kernel 216 after 4 beats, o_ovf=0.
REQ-035 Weights -128, data -128, accum_len=4, saturate -> 524287, o_ovf=1; wrap mode -> -458752, o_ovf=1.
REQ-036 i_psum_rdy low 5 cycles in OUT -> o_psum stable, o_data_rdy=0 throughout, transfer on 6th cycle.
REQ-037 interval=2, kernel k weights = k+1, data 1 -> two results 9(k+1), then WLOAD; reload weights 2 -> third result 18 for all kernels.
REQ-038 rst asserted after 2 of 4 beats -> all outputs 0 next cycle; rerun with enable yields results from fresh accumulation only.
